// File: rtl/neighbor_force_scanner_if.sv
// Signal bundle between the neighbor force scanner and its environment:
// start/center request, frame-memory read port, inverse-cube LUT port and results.
interface neighbor_force_scanner_if;
    logic        start;
    logic [6:0]  center_x;
    logic [5:0]  center_y;
    logic        ready;
    logic        pix_rd_en;
    logic [6:0]  pix_addr_x;
    logic [5:0]  pix_addr_y;
    logic        pix_data;
    logic [6:0]  x_dist;
    logic [5:0]  y_dist;
    logic [19:0] inv_distance_cube;
    logic [31:0] force_x;
    logic [31:0] force_y;
    logic        done;

    // The scanner is the initiator of memory reads and LUT lookups.
    modport master (
        input  start, center_x, center_y, pix_data, inv_distance_cube,
        output ready, pix_rd_en, pix_addr_x, pix_addr_y, x_dist, y_dist,
               force_x, force_y, done
    );

    modport slave (
        output start, center_x, center_y, pix_data, inv_distance_cube,
        input  ready, pix_rd_en, pix_addr_x, pix_addr_y, x_dist, y_dist,
               force_x, force_y, done
    );
endinterface

// File: rtl/neighbor_force_scanner.sv
// Scans a (2R+1)^2 window around a center pixel, reads occupancy and accumulates
// signed inverse-distance-cube force components from the LUT.
module neighbor_force_scanner #(
    parameter int unsigned RADIUS = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    neighbor_force_scanner_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

    localparam logic signed [7:0] RadX = 8'(RADIUS);
    localparam logic signed [6:0] RadY = 7'(RADIUS);

    state_e             state_q;
    logic [6:0]         cx_q;
    logic [5:0]         cy_q;
    logic signed [7:0]  dx_q;
    logic signed [6:0]  dy_q;
    logic               rd_en_q;
    logic [6:0]         addr_x_q;
    logic [5:0]         addr_y_q;
    logic               s1_valid_q;
    logic signed [7:0]  s1_dx_q;
    logic signed [6:0]  s1_dy_q;
    logic signed [31:0] acc_x_q, acc_y_q;
    logic signed [31:0] force_x_q, force_y_q;
    logic               done_q;
    logic               ready_q;

    logic [6:0]         cx_src;
    logic [5:0]         cy_src;
    logic signed [7:0]  nx;
    logic signed [6:0]  ny;
    logic               last_offset;
    logic               issue_next;
    logic signed [7:0]  tx;
    logic signed [6:0]  ty;
    logic               rd_next;

    // Next offset and its read strobe, registered so pix_rd_en leaves a flop.
    always_comb begin
        cx_src      = (state_q == StIdle) ? bus.center_x : cx_q;
        cy_src      = (state_q == StIdle) ? bus.center_y : cy_q;
        last_offset = (dx_q == RadX) && (dy_q == RadY);
        issue_next  = 1'b0;
        nx          = dx_q;
        ny          = dy_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    issue_next = 1'b1;
                    nx         = -RadX;
                    ny         = -RadY;
                end
            end
            StScan: begin
                if (!last_offset) begin
                    issue_next = 1'b1;
                    if (dx_q == RadX) begin
                        nx = -RadX;
                        ny = dy_q + 7'sd1;
                    end else begin
                        nx = dx_q + 8'sd1;
                    end
                end
            end
            default: ;
        endcase
        tx      = $signed({1'b0, cx_src}) + nx;
        ty      = $signed({1'b0, cy_src}) + ny;
        // A negative signed target is either left/top of screen or wrapped past 127/63.
        rd_next = issue_next && !tx[7] && !ty[6];
    end

    logic signed [31:0] dx_ext, dy_ext, inv_ext;
    logic signed [31:0] prod_x, prod_y;
    logic signed [31:0] acc_x_next, acc_y_next;
    logic               hit;

    always_comb begin
        dx_ext     = {{24{s1_dx_q[7]}}, s1_dx_q};
        dy_ext     = {{25{s1_dy_q[6]}}, s1_dy_q};
        inv_ext    = {12'b0, bus.inv_distance_cube};
        prod_x     = dx_ext * inv_ext;
        prod_y     = dy_ext * inv_ext;
        hit        = s1_valid_q && bus.pix_data;
        acc_x_next = hit ? acc_x_q + prod_x : acc_x_q;
        acc_y_next = hit ? acc_y_q + prod_y : acc_y_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cx_q       <= '0;
            cy_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            rd_en_q    <= 1'b0;
            addr_x_q   <= '0;
            addr_y_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            force_x_q  <= '0;
            force_y_q  <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            dx_q       <= nx;
            dy_q       <= ny;
            rd_en_q    <= rd_next;
            if (rd_next) begin
                addr_x_q <= tx[6:0];
                addr_y_q <= ty[5:0];
            end
            s1_valid_q <= rd_en_q;
            s1_dx_q    <= dx_q;
            s1_dy_q    <= dy_q;
            acc_x_q    <= acc_x_next;
            acc_y_q    <= acc_y_next;
            done_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        cx_q    <= bus.center_x;
                        cy_q    <= bus.center_y;
                        acc_x_q <= '0;
                        acc_y_q <= '0;
                        ready_q <= 1'b0;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    if (last_offset) state_q <= StDrain;
                end
                StDrain: begin
                    // Fold in the final offset's contribution landing this cycle.
                    force_x_q <= acc_x_next;
                    force_y_q <= acc_y_next;
                    done_q    <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.pix_rd_en  = rd_en_q;
    assign bus.pix_addr_x = addr_x_q;
    assign bus.pix_addr_y = addr_y_q;
    assign bus.x_dist     = 7'(s1_dx_q[7] ? -s1_dx_q : s1_dx_q);
    assign bus.y_dist     = 6'(s1_dy_q[6] ? -s1_dy_q : s1_dy_q);
    assign bus.force_x    = force_x_q;
    assign bus.force_y    = force_y_q;
    assign bus.done       = done_q;

endmodule
